// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle between IF3, the instruction fetch queue and decode.
interface inst_fetch_queue_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             in_valid0;
    logic [31:0]      in_pc0;
    logic [31:0]      in_inst0;
    logic             in_valid1;
    logic [31:0]      in_pc1;
    logic [31:0]      in_inst1;
    logic             dec_stall;
    logic             pause_req;
    logic             out_valid0;
    logic [31:0]      out_pc0;
    logic [31:0]      out_inst0;
    logic             out_valid1;
    logic [31:0]      out_pc1;
    logic [31:0]      out_inst1;
    logic [CNT_W-1:0] occupancy;

    // Fetch/decode side: drives instructions, flush and stall; observes the queue.
    modport master (
        output flush, in_valid0, in_pc0, in_inst0, in_valid1, in_pc1, in_inst1, dec_stall,
        input  pause_req, out_valid0, out_pc0, out_inst0, out_valid1, out_pc1, out_inst1,
               occupancy
    );

    // Queue side.
    modport slave (
        input  flush, in_valid0, in_pc0, in_inst0, in_valid1, in_pc1, in_inst1, dec_stall,
        output pause_req, out_valid0, out_pc0, out_inst0, out_valid1, out_pc1, out_inst1,
               occupancy
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Two-in / two-out first-word-fall-through instruction buffer between IF3 and decode.
module inst_fetch_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_queue_if.slave   q
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             pause_c;
    logic             wr0_en_c;
    logic             wr1_en_c;
    logic [31:0]      wr0_pc_c;
    logic [31:0]      wr0_inst_c;
    logic [1:0]       push_n_c;
    logic [1:0]       pop_n_c;
    logic [PTR_W-1:0] rd_ptr1_c;
    logic [PTR_W-1:0] wr_ptr1_c;

    // Push/pop decisions; valid lanes are compacted so a lone lane 1 lands at wr_ptr.
    always_comb begin
        pause_c    = count >= CNT_W'(DEPTH - 1);
        wr0_en_c   = !pause_c && !q.flush && (q.in_valid0 || q.in_valid1);
        wr1_en_c   = !pause_c && !q.flush && q.in_valid0 && q.in_valid1;
        wr0_pc_c   = q.in_valid0 ? q.in_pc0   : q.in_pc1;
        wr0_inst_c = q.in_valid0 ? q.in_inst0 : q.in_inst1;
        push_n_c   = {1'b0, wr0_en_c} + {1'b0, wr1_en_c};
        pop_n_c    = 2'd0;
        if (!q.flush && !q.dec_stall) begin
            pop_n_c = (count >= CNT_W'(2)) ? 2'd2 : {1'b0, count[0]};
        end
        rd_ptr1_c  = rd_ptr + PTR_W'(1);
        wr_ptr1_c  = wr_ptr + PTR_W'(1);
    end

    // Pointer and count update; flush clears everything and drops same-cycle inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (q.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop_n_c);
            wr_ptr <= wr_ptr + PTR_W'(push_n_c);
            count  <= count + CNT_W'(push_n_c) - CNT_W'(pop_n_c);
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr0_en_c) begin
            pc_mem[wr_ptr]   <= wr0_pc_c;
            inst_mem[wr_ptr] <= wr0_inst_c;
        end
        if (wr1_en_c) begin
            pc_mem[wr_ptr1_c]   <= q.in_pc1;
            inst_mem[wr_ptr1_c] <= q.in_inst1;
        end
    end

    assign q.pause_req  = pause_c;
    assign q.occupancy  = count;
    assign q.out_valid0 = count != '0;
    assign q.out_valid1 = count >= CNT_W'(2);
    assign q.out_pc0    = pc_mem[rd_ptr];
    assign q.out_inst0  = inst_mem[rd_ptr];
    assign q.out_pc1    = pc_mem[rd_ptr1_c];
    assign q.out_inst1  = inst_mem[rd_ptr1_c];
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench: directed vector table, hand sequences and a random run against a queue model.
module tb_inst_fetch_queue;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_queue_if #(.DEPTH(DEPTH)) bus ();
    inst_fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(bus));

    typedef struct {
        logic        f;
        logic        v0;
        logic        v1;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic        st;
        int          occ;
        logic        pause;
        logic        ov0;
        logic        ov1;
        logic [31:0] epc0;
        logic [31:0] epc1;
    } vec_t;

    vec_t        tbl[$];
    logic [63:0] mq[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic vec_t mk(input logic f, input logic v0, input logic v1,
                                input logic [31:0] pc0, input logic [31:0] pc1, input logic st,
                                input int occ, input logic pause, input logic ov0, input logic ov1,
                                input logic [31:0] epc0, input logic [31:0] epc1);
        vec_t v;
        v.f = f; v.v0 = v0; v.v1 = v1; v.pc0 = pc0; v.pc1 = pc1; v.st = st;
        v.occ = occ; v.pause = pause; v.ov0 = ov0; v.ov1 = ov1; v.epc0 = epc0; v.epc1 = epc1;
        return v;
    endfunction

    function automatic logic [31:0] iw(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic f, input logic v0, input logic v1,
                         input logic [31:0] pc0, input logic [31:0] i0,
                         input logic [31:0] pc1, input logic [31:0] i1, input logic st);
        bus.flush     = f;
        bus.in_valid0 = v0;
        bus.in_pc0    = pc0;
        bus.in_inst0  = i0;
        bus.in_valid1 = v1;
        bus.in_pc1    = pc1;
        bus.in_inst1  = i1;
        bus.dec_stall = st;
    endtask

    // Compare DUT outputs against the model queue contents.
    task automatic model_check();
        int sz;
        sz = mq.size();
        chk("rnd_occ",   32'(bus.occupancy),  32'(sz));
        chk("rnd_pause", 32'(bus.pause_req),  32'((DEPTH - sz) < 2));
        chk("rnd_ov0",   32'(bus.out_valid0), 32'(sz >= 1));
        chk("rnd_ov1",   32'(bus.out_valid1), 32'(sz >= 2));
        if (sz >= 1) begin
            chk("rnd_pc0",   bus.out_pc0,   mq[0][63:32]);
            chk("rnd_inst0", bus.out_inst0, mq[0][31:0]);
        end
        if (sz >= 2) begin
            chk("rnd_pc1",   bus.out_pc1,   mq[1][63:32]);
            chk("rnd_inst1", bus.out_inst1, mq[1][31:0]);
        end
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        int  sz;
        bit  paused;
        sz     = mq.size();
        paused = (DEPTH - sz) < 2;
        if (bus.flush) begin
            mq.delete();
        end else begin
            if (!bus.dec_stall) begin
                for (int k = 0; k < 2 && mq.size() > 0; k++) void'(mq.pop_front());
            end
            if (!paused) begin
                if (bus.in_valid0) mq.push_back({bus.in_pc0, bus.in_inst0});
                if (bus.in_valid1) mq.push_back({bus.in_pc1, bus.in_inst1});
            end
        end
    endtask

    initial begin
        logic [31:0] pc_next;
        logic        f, v0, v1, st;

        // Directed table: inputs for the cycle, outputs expected during that cycle.
        tbl.push_back(mk(0,0,0,32'h0,   32'h0,   1, 0,0,0,0,32'h0,   32'h0));
        tbl.push_back(mk(0,1,1,32'h1000,32'h1004,1, 0,0,0,0,32'h0,   32'h0));
        tbl.push_back(mk(0,1,1,32'h1008,32'h100C,1, 2,0,1,1,32'h1000,32'h1004));
        tbl.push_back(mk(0,1,1,32'h1010,32'h1014,1, 4,0,1,1,32'h1000,32'h1004));
        tbl.push_back(mk(0,1,1,32'h1018,32'h101C,1, 6,0,1,1,32'h1000,32'h1004));
        tbl.push_back(mk(0,1,1,32'h1020,32'h1024,1, 8,1,1,1,32'h1000,32'h1004));
        tbl.push_back(mk(0,1,1,32'h1020,32'h1024,1, 8,1,1,1,32'h1000,32'h1004));
        tbl.push_back(mk(0,1,1,32'h1020,32'h1024,0, 8,1,1,1,32'h1000,32'h1004));
        tbl.push_back(mk(0,1,1,32'h1020,32'h1024,0, 6,0,1,1,32'h1008,32'h100C));
        tbl.push_back(mk(0,0,0,32'h0,   32'h0,   0, 6,0,1,1,32'h1010,32'h1014));
        tbl.push_back(mk(0,0,0,32'h0,   32'h0,   0, 4,0,1,1,32'h1018,32'h101C));
        tbl.push_back(mk(0,0,0,32'h0,   32'h0,   0, 2,0,1,1,32'h1020,32'h1024));
        tbl.push_back(mk(0,0,1,32'h0,   32'h2004,0, 0,0,0,0,32'h0,   32'h0));
        tbl.push_back(mk(0,1,0,32'h2008,32'h0,   0, 1,0,1,0,32'h2004,32'h0));
        tbl.push_back(mk(0,0,0,32'h0,   32'h0,   0, 1,0,1,0,32'h2008,32'h0));
        tbl.push_back(mk(0,0,0,32'h0,   32'h0,   1, 0,0,0,0,32'h0,   32'h0));
        tbl.push_back(mk(0,1,1,32'h3000,32'h3004,1, 0,0,0,0,32'h0,   32'h0));
        tbl.push_back(mk(0,1,1,32'h3008,32'h300C,1, 2,0,1,1,32'h3000,32'h3004));
        tbl.push_back(mk(0,1,1,32'h3010,32'h3014,1, 4,0,1,1,32'h3000,32'h3004));
        tbl.push_back(mk(1,1,1,32'h4000,32'h4004,1, 6,0,1,1,32'h3000,32'h3004));
        tbl.push_back(mk(0,1,1,32'h5000,32'h5004,1, 0,0,0,0,32'h0,   32'h0));
        tbl.push_back(mk(0,0,0,32'h0,   32'h0,   1, 2,0,1,1,32'h5000,32'h5004));

        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1);
        repeat (2) @(negedge clk);
        chk("reset_occ",   32'(bus.occupancy),  32'd0);
        chk("reset_ov0",   32'(bus.out_valid0), 32'd0);
        chk("reset_pause", 32'(bus.pause_req),  32'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].f, tbl[i].v0, tbl[i].v1, tbl[i].pc0, iw(tbl[i].pc0),
                  tbl[i].pc1, iw(tbl[i].pc1), tbl[i].st);
            chk($sformatf("vec%0d_occ", i),   32'(bus.occupancy),  32'(tbl[i].occ));
            chk($sformatf("vec%0d_pause", i), 32'(bus.pause_req),  32'(tbl[i].pause));
            chk($sformatf("vec%0d_ov0", i),   32'(bus.out_valid0), 32'(tbl[i].ov0));
            chk($sformatf("vec%0d_ov1", i),   32'(bus.out_valid1), 32'(tbl[i].ov1));
            if (tbl[i].ov0) begin
                chk($sformatf("vec%0d_pc0", i),   bus.out_pc0,   tbl[i].epc0);
                chk($sformatf("vec%0d_inst0", i), bus.out_inst0, iw(tbl[i].epc0));
            end
            if (tbl[i].ov1) begin
                chk($sformatf("vec%0d_pc1", i),   bus.out_pc1,   tbl[i].epc1);
                chk($sformatf("vec%0d_inst1", i), bus.out_inst1, iw(tbl[i].epc1));
            end
        end

        // Grow to five entries, then assert reset between edges: outputs must drop at once.
        @(negedge clk);
        drive(0, 1, 1, 32'h6000, iw(32'h6000), 32'h6004, iw(32'h6004), 1);
        @(negedge clk);
        drive(0, 1, 0, 32'h6008, iw(32'h6008), 32'h0, 32'h0, 1);
        @(negedge clk);
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1);
        chk("pre_rst_occ", 32'(bus.occupancy), 32'd5);
        rst = 1'b1;
        #1;
        chk("async_rst_occ",   32'(bus.occupancy),  32'd0);
        chk("async_rst_ov0",   32'(bus.out_valid0), 32'd0);
        chk("async_rst_ov1",   32'(bus.out_valid1), 32'd0);
        chk("async_rst_pause", 32'(bus.pause_req),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the queue model; exercises wrap, stalls and flushes.
        mq.delete();
        pc_next = 32'h8000;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            f  = ($urandom_range(0, 39) == 0);
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 2) == 0);
            if (c < 300) st = 1'(c % 2);
            drive(f, v0, v1, pc_next, $urandom(), pc_next + 32'd4, $urandom(), st);
            pc_next = pc_next + 32'd8;
            model_check();
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
